// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - measures period and high time of a slow asynchronous clock in sys_clk cycles
// Also reports lock on a stable period and a sticky timeout when clk_in stalls.
module clk_period_meter #(
  parameter int unsigned      CNT_W    = 16,
  parameter logic [CNT_W-1:0] TIMEOUT  = 16'd1000,
  parameter logic [2:0]       LOCK_CNT = 3'd4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             meta_q, sync_q, sync_dly_q;
  logic [CNT_W-1:0] cnt_per_q, cnt_per_d;
  logic [CNT_W-1:0] cnt_hi_q, cnt_hi_d;
  logic [CNT_W-1:0] hi_latch_q, hi_latch_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic [2:0]       match_cnt_q, match_cnt_d;
  logic             rise, fall;

  assign rise = sync_q & ~sync_dly_q;
  assign fall = ~sync_q & sync_dly_q;

  always_comb begin
    state_d     = state_q;
    cnt_per_d   = cnt_per_q;
    cnt_hi_d    = cnt_hi_q;
    hi_latch_d  = hi_latch_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    match_cnt_d = match_cnt_q;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d   = MEASURE;
          cnt_per_d = CNT_ONE;
          cnt_hi_d  = CNT_ONE;
        end
      end

      MEASURE: begin
        if (rise) begin
          period_d    = cnt_per_q;
          high_time_d = hi_latch_q;
          valid_d     = 1'b1;
          timeout_d   = 1'b0;
          cnt_per_d   = CNT_ONE;
          cnt_hi_d    = CNT_ONE;
          // period_q is zero only after reset or timeout, so it doubles as "no previous period"
          if ((period_q != '0) && (cnt_per_q == period_q)) begin
            match_cnt_d = (match_cnt_q == LOCK_CNT) ? LOCK_CNT : match_cnt_q + 3'd1;
          end else begin
            match_cnt_d = 3'd0;
          end
          locked_d = (match_cnt_d == LOCK_CNT);
        end else if (cnt_per_q == TIMEOUT) begin
          state_d     = IDLE;
          timeout_d   = 1'b1;
          locked_d    = 1'b0;
          match_cnt_d = 3'd0;
          period_d    = '0;
          high_time_d = '0;
          cnt_per_d   = '0;
          cnt_hi_d    = '0;
        end else begin
          if (cnt_per_q != CNT_MAX) begin
            cnt_per_d = cnt_per_q + CNT_ONE;
          end
          if (sync_q && (cnt_hi_q != CNT_MAX)) begin
            cnt_hi_d = cnt_hi_q + CNT_ONE;
          end
          if (fall) begin
            hi_latch_d = cnt_hi_q;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      meta_q      <= 1'b0;
      sync_q      <= 1'b0;
      sync_dly_q  <= 1'b0;
      cnt_per_q   <= '0;
      cnt_hi_q    <= '0;
      hi_latch_q  <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      match_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      meta_q      <= clk_in;
      sync_q      <= meta_q;
      sync_dly_q  <= sync_q;
      cnt_per_q   <= cnt_per_d;
      cnt_hi_q    <= cnt_hi_d;
      hi_latch_q  <= hi_latch_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - randomized self-checking bench for clk_period_meter
// The reference derives each expected measurement from the timestamps of the edges it drives.
module tb_clk_period_meter;

  localparam int CNT_W    = 16;
  localparam int TIMEOUT  = 1000;
  localparam int LOCK_CNT = 4;

  logic             sys_clk;
  logic             sys_rst_n;
  logic             clk_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             locked;
  logic             timeout;

  clk_period_meter dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clk_in    (clk_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .locked    (locked),
    .timeout   (timeout)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int per;
    int hi;
    int t;
    bit lk;
  } exp_t;

  exp_t exp_q[$];
  int   hist[$];
  bit   armed;
  bit   exp_locked;
  int   last_rise;
  int   last_fall;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_idle();
    armed      = 1'b0;
    exp_locked = 1'b0;
    hist.delete();
  endtask

  // Locked means the last LOCK_CNT+1 periods since leaving idle were all equal.
  task automatic note_rise();
    exp_t e;
    bit   same;
    if (armed) begin
      e.per = cyc - last_rise;
      e.hi  = last_fall - last_rise;
      e.t   = cyc;
      hist.push_back(e.per);
      same = (hist.size() >= LOCK_CNT + 1);
      if (same) begin
        for (int k = hist.size() - LOCK_CNT - 1; k < hist.size(); k++) begin
          if (hist[k] != e.per) same = 1'b0;
        end
      end
      exp_locked = same;
      e.lk = same;
      exp_q.push_back(e);
    end
    armed     = 1'b1;
    last_rise = cyc;
  endtask

  task automatic drive_period(input int h, input int l);
    clk_in = 1'b1;
    note_rise();
    repeat (h) @(negedge sys_clk);
    clk_in    = 1'b0;
    last_fall = cyc;
    repeat (l) @(negedge sys_clk);
  endtask

  initial begin : checker_proc
    exp_t e;
    int   lat;
    forever begin
      @(posedge sys_clk);
      #1;
      if (sys_rst_n && valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_valid", valid, 1'b0);
        end else begin
          e   = exp_q.pop_front();
          lat = cyc - e.t;
          check_eq("period", 32'(period), e.per);
          check_eq("high_time", 32'(high_time), e.hi);
          check_eq("locked_at_valid", locked, e.lk);
          check_eq("timeout_at_valid", timeout, 1'b0);
          check_eq("valid_latency_le3", (lat >= 1 && lat <= 3), 1'b1);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int h, l, reps, dt;
    sys_rst_n = 1'b0;
    clk_in    = 1'b0;
    last_rise = 0;
    last_fall = 0;
    model_idle();

    repeat (3) @(negedge sys_clk);
    check_eq("reset_period", 32'(period), 0);
    check_eq("reset_high_time", 32'(high_time), 0);
    check_eq("reset_valid", valid, 1'b0);
    check_eq("reset_locked", locked, 1'b0);
    check_eq("reset_timeout", timeout, 1'b0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    for (int i = 0; i < 7; i++) drive_period(3, 3);
    check_eq("locked_3h3l", locked, exp_locked);
    for (int i = 0; i < 6; i++) drive_period(4, 6);
    check_eq("locked_4h6l", locked, exp_locked);
    for (int i = 0; i < 10; i++) drive_period(1, 1);
    check_eq("locked_1h1l", locked, exp_locked);

    for (int s = 0; s < 15; s++) begin
      h    = $urandom_range(1, 8);
      l    = $urandom_range(1, 8);
      reps = $urandom_range(1, 7);
      for (int r = 0; r < reps; r++) drive_period(h, l);
    end

    // A period equal to TIMEOUT: rise and timeout coincide, the rise must win.
    drive_period(4, TIMEOUT - 4);
    for (int i = 0; i < 6; i++) drive_period(3, 3);
    check_eq("locked_before_stall", locked, exp_locked);

    for (int i = 0; i < 1200 && !timeout; i++) @(negedge sys_clk);
    dt = cyc - last_rise;
    check_eq("timeout_set", timeout, 1'b1);
    check_eq("timeout_delay_in_range", (dt >= TIMEOUT && dt <= TIMEOUT + 3), 1'b1);
    check_eq("timeout_period", 32'(period), 0);
    check_eq("timeout_high_time", 32'(high_time), 0);
    check_eq("timeout_locked", locked, 1'b0);
    model_idle();

    drive_period(3, 3);
    check_eq("timeout_sticky", timeout, 1'b1);
    for (int i = 0; i < 6; i++) drive_period(3, 3);
    check_eq("timeout_cleared", timeout, 1'b0);
    check_eq("relocked_after_timeout", locked, exp_locked);

    clk_in = 1'b1;
    note_rise();
    repeat (3) @(negedge sys_clk);
    clk_in    = 1'b0;
    last_fall = cyc;
    @(negedge sys_clk);
    check_eq("locked_before_reset", locked, exp_locked);
    sys_rst_n = 1'b0;
    #1;
    check_eq("midrst_period", 32'(period), 0);
    check_eq("midrst_high_time", 32'(high_time), 0);
    check_eq("midrst_valid", valid, 1'b0);
    check_eq("midrst_locked", locked, 1'b0);
    check_eq("midrst_timeout", timeout, 1'b0);
    model_idle();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    for (int i = 0; i < 5; i++) drive_period(3, 3);
    repeat (5) @(negedge sys_clk);
    check_eq("pending_valids", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
